// File: rtl/fifo_stream_reader_if.sv
// Signal bundle between the FIFO read port, the stream drainer and the consumer.
// The master modport belongs to the drainer; the slave modport to the FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_re;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [1:0]            level;

  modport master (
    input  fifo_empty,
    input  fifo_q,
    input  m_ready,
    output fifo_re,
    output m_valid,
    output m_data,
    output m_last,
    output level
  );

  modport slave (
    output fifo_empty,
    output fifo_q,
    output m_ready,
    input  fifo_re,
    input  m_valid,
    input  m_data,
    input  m_last,
    input  level
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side drainer: pops a BRAM FIFO and hides its 1-cycle read latency behind a 2-entry buffer.
// Optional frame-end marker on m_last is enabled by defining FIFO_STREAM_READER_LAST_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  fifo_stream_reader_if.master bus
);

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Elaboration-time guard on the parameter ranges.
  if (DATA_WIDTH < 1 || DATA_WIDTH > 16) begin : g_bad_width
    $error("fifo_stream_reader: DATA_WIDTH out of range");
  end
  if (BURST_LEN < 1 || BURST_LEN > 65535) begin : g_bad_burst
    $error("fifo_stream_reader: BURST_LEN out of range");
  end

  logic [1:0] occ_q;
  logic [1:0] occ_d;
  logic       inflight_q;
  logic       inflight_d;
  word_t      buf0_q;
  word_t      buf0_d;
  word_t      buf1_q;
  word_t      buf1_d;

  logic       valid;
  logic       pop;
  logic       re;
  logic [1:0] pend;

  // Handshake and read-enable: pend is the committed occupancy after this
  // cycle's pop and capture; a new read is only issued if it still fits.
  always_comb begin
    valid      = (occ_q != 2'd0);
    pop        = valid & bus.m_ready;
    pend       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    re         = ~rst & ~bus.fifo_empty & (pend < 2'd2);
    occ_d      = pend;
    inflight_d = re;
  end

  // Buffer update: shift on pop, then land the in-flight word in the
  // first free slot. Unused slots are kept at zero.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      buf0_d = buf1_q;
      buf1_d = '0;
    end
    if (inflight_q) begin
      if (pend == 2'd2) begin
        buf1_d = bus.fifo_q;
      end else begin
        buf0_d = bus.fifo_q;
      end
    end
  end

  // Occupancy, in-flight flag and buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign bus.fifo_re = re;
  assign bus.m_valid = valid;
  assign bus.m_data  = buf0_q;
  assign bus.level   = occ_q;

`ifdef FIFO_STREAM_READER_LAST_EN
  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Frame counter: advances per pop, wraps after the last word of a frame.
  always_comb begin
    cnt_d = cnt_q;
    if (pop) begin
      cnt_d = (cnt_q == LAST_IDX) ? 16'd0 : cnt_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.m_last = valid & (cnt_q == LAST_IDX);
`else
  assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO.
// m_last expectations follow FIFO_STREAM_READER_LAST_EN.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:511];
  int wr_cnt = 0;
  int rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_cnt);

  always @(posedge clk) begin
    if (bus.fifo_re) begin
      bus.fifo_q <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int re_cnt = 0;
  int recv [$];
  logic lastq [$];
  int acc_cyc [$];

  task automatic push(input logic [DW-1:0] w);
    mem[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic tick();
    logic acc;
    logic [DW-1:0] d;
    logic l;
    logic r;
    #1;
    acc = bus.m_valid & bus.m_ready;
    d = bus.m_data;
    l = bus.m_last;
    r = bus.fifo_re;
    if (r) re_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      recv.push_back(int'(d));
      lastq.push_back(l);
      acc_cyc.push_back(cyc);
    end
    n_chk++;
    if (int'(bus.level) + int'(r) > 2) begin
      n_fail++;
      $display("FAIL occ_bound: level+inflight=%0d required <=2",
               int'(bus.level) + int'(r));
    end
  endtask

  task automatic test_reset();
    logic [DW+4:0] o;
    #2;
    o = {bus.m_valid, bus.m_data, bus.m_last, bus.level, bus.fifo_re};
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h required 0", o);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if ({bus.fifo_re, bus.m_valid, bus.level} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle_empty: cycle %0d got re=%b v=%b lvl=%0d required 0",
                 i, bus.fifo_re, bus.m_valid, bus.level);
      end
    end
  endtask

  task automatic test_three();
    logic [7:0] re_v;
    logic [7:0] val_v;
    int exp_w [3];
    exp_w = '{'h11, 'h22, 'h33};
    recv.delete();
    bus.m_ready = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    for (int i = 0; i < 8; i++) begin
      #1;
      re_v[i] = bus.fifo_re;
      val_v[i] = bus.m_valid;
      tick();
    end
    n_chk++;
    if (re_v !== 8'b0000_0111) begin
      n_fail++;
      $display("FAIL three_re: got %b required 00000111", re_v);
    end
    n_chk++;
    if (val_v !== 8'b0001_1100) begin
      n_fail++;
      $display("FAIL three_valid: got %b required 00011100", val_v);
    end
    n_chk++;
    if (recv.size() != 3) begin
      n_fail++;
      $display("FAIL three_count: got %0d required 3", recv.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (recv[i] != exp_w[i]) begin
          n_fail++;
          $display("FAIL three_data[%0d]: got %0h required %0h",
                   i, recv[i], exp_w[i]);
        end
      end
    end
    n_chk++;
    if (bus.level !== 2'd0) begin
      n_fail++;
      $display("FAIL three_level: got %0d required 0", bus.level);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    recv.delete();
    acc_cyc.delete();
    bus.m_ready = 1'b0;
    re_cnt = 0;
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    repeat (6) tick();
    n_chk++;
    if (re_cnt != 2) begin
      n_fail++;
      $display("FAIL bp_re_pulses: got %0d required 2", re_cnt);
    end
    n_chk++;
    if ({bus.level, bus.m_valid, bus.m_data} !== {2'd2, 1'b1, 8'hA0}) begin
      n_fail++;
      $display("FAIL bp_stall: got lvl=%0d v=%b d=%0h required lvl=2 v=1 d=a0",
               bus.level, bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    guard = 0;
    while (recv.size() < 8 && guard < 40) begin
      tick();
      guard++;
    end
    n_chk++;
    if (recv.size() != 8) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d words required 8", recv.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (recv[i] != 'hA0 + i) begin
          n_fail++;
          $display("FAIL bp_data[%0d]: got %0h required %0h",
                   i, recv[i], 'hA0 + i);
        end
      end
      n_chk++;
      if (acc_cyc[7] - acc_cyc[0] != 7) begin
        n_fail++;
        $display("FAIL bp_gapless: got span %0d required 7",
                 acc_cyc[7] - acc_cyc[0]);
      end
    end
    n_chk++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: got v=%b required 0", bus.m_valid);
    end
  endtask

  task automatic test_toggle();
    int guard;
    recv.delete();
    for (int i = 0; i < 100; i++) push(8'(i));
    bus.m_ready = 1'b1;
    guard = 0;
    while (recv.size() < 100 && guard < 600) begin
      tick();
      bus.m_ready = ~bus.m_ready;
      guard++;
    end
    n_chk++;
    if (recv.size() != 100) begin
      n_fail++;
      $display("FAIL toggle_timeout: got %0d words required 100", recv.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        n_chk++;
        if (recv[i] != i) begin
          n_fail++;
          $display("FAIL toggle_data[%0d]: got %0d required %0d", i, recv[i], i);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    logic [DW+4:0] o;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    tick();
    tick();
    n_chk++;
    if (bus.level !== 2'd1 || bus.fifo_re !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_setup: got lvl=%0d re=%b required lvl=1 re=0",
               bus.level, bus.fifo_re);
    end
    #2;
    rst = 1'b1;
    #1;
    o = {bus.m_valid, bus.m_data, bus.m_last, bus.level, bus.fifo_re};
    n_chk++;
    if (o !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: got %0h required 0", o);
    end
    tick();
    rst = 1'b0;
    recv.delete();
    bus.m_ready = 1'b1;
    guard = 0;
    while (recv.size() < 4 && guard < 30) begin
      tick();
      guard++;
    end
    n_chk++;
    if (recv.size() != 4) begin
      n_fail++;
      $display("FAIL rmid_timeout: got %0d words required 4", recv.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (recv[i] != 'hC2 + i) begin
          n_fail++;
          $display("FAIL rmid_data[%0d]: got %0h required %0h",
                   i, recv[i], 'hC2 + i);
        end
      end
    end
  endtask

  task automatic test_last();
    logic [39:0] pat;
    int guard;
    logic pv;
    logic pr;
    logic pl;
    logic [DW-1:0] pd;
    logic exp_l;
    pat = 40'hB5_AD_6B_D6_5B;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    recv.delete();
    lastq.delete();
    for (int i = 0; i < 12; i++) push(8'(8'hD0 + i));
    guard = 0;
    while (recv.size() < 12 && guard < 200) begin
      bus.m_ready = (guard < 40) ? pat[guard] : 1'b1;
      #1;
      pv = bus.m_valid;
      pr = bus.m_ready;
      pl = bus.m_last;
      pd = bus.m_data;
      tick();
      if (pv && !pr) begin
        n_chk++;
        if ({bus.m_valid, bus.m_last, bus.m_data} !== {1'b1, pl, pd}) begin
          n_fail++;
          $display("FAIL last_stall: got v=%b l=%b d=%0h required v=1 l=%b d=%0h",
                   bus.m_valid, bus.m_last, bus.m_data, pl, pd);
        end
      end
      guard++;
    end
    n_chk++;
    if (recv.size() != 12) begin
      n_fail++;
      $display("FAIL last_timeout: got %0d words required 12", recv.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
`ifdef FIFO_STREAM_READER_LAST_EN
        exp_l = ((i + 1) % BL == 0);
`else
        exp_l = 1'b0;
`endif
        n_chk++;
        if (lastq[i] !== exp_l || recv[i] != 'hD0 + i) begin
          n_fail++;
          $display("FAIL last_xfer[%0d]: got l=%b d=%0h required l=%b d=%0h",
                   i, lastq[i], recv[i], exp_l, 'hD0 + i);
        end
      end
    end
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_three();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_last();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
